// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the MIPS fetch stage: special instruction encodings
// and the program counter value taken on reset.
package instruction_fetch_pkg;

    localparam logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction store: one synchronous write port for the loader and one
// asynchronous read port for fetch. Contents are deliberately not reset so a
// loaded program survives a pipeline reset.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int N_WORDS = 1024,
    parameter int NB_ADDR = $clog2(N_WORDS)
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    logic [NB_DATA-1:0] mem [N_WORDS];

    // Loader write; a same-cycle read of this word still sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Combinational fetch read.
    always_comb begin
        o_rd_data = mem[i_rd_addr];
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, instruction memory and the IF/ID
// pipeline register, with stall, flush, redirect and HALT handling.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter  int NB_PC        = 32,
    parameter  int NB_INSTR     = 32,
    parameter  int N_IMEM_WORDS = 1024,
    localparam int NB_IMEM_ADDR = $clog2(N_IMEM_WORDS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pipe_enabled,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_pc_src,
    input  logic [NB_PC-1:0]        i_pc_target,
    input  logic                    i_load_enable,
    input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
    input  logic [NB_INSTR-1:0]     i_load_data,
    output logic [NB_INSTR-1:0]     o_instruction,
    output logic [NB_PC-1:0]        o_pc_plus4,
    output logic [NB_PC-1:0]        o_pc,
    output logic                    o_halt
);

    logic [NB_PC-1:0]        pc_p0;
    logic [NB_INSTR-1:0]     instr_p1;
    logic [NB_PC-1:0]        pc_plus4_p1;
    logic                    halted;

    logic [NB_PC-1:0]        pc_plus4_p0;
    logic [NB_IMEM_ADDR-1:0] fetch_addr_p0;
    logic [NB_INSTR-1:0]     fetch_word_p0;
    logic                    advance;
    logic                    fetch_is_halt;

    instruction_memory #(
        .NB_DATA (NB_INSTR),
        .N_WORDS (N_IMEM_WORDS),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (i_load_enable),
        .i_wr_addr (i_load_addr),
        .i_wr_data (i_load_data),
        .i_rd_addr (fetch_addr_p0),
        .o_rd_data (fetch_word_p0)
    );

    // Word index from the PC (byte address, upper bits wrap) and advance qualification.
    always_comb begin
        pc_plus4_p0   = pc_p0 + NB_PC'(4);
        fetch_addr_p0 = NB_IMEM_ADDR'(pc_p0 >> 2);
        advance       = i_pipe_enabled && !i_stall && !halted;
        fetch_is_halt = (fetch_word_p0 == NB_INSTR'(HALT_INSTR));
    end

    // ---- stage 0 -> stage 1: PC update, IF/ID capture and halt latch ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_p0       <= NB_PC'(PC_RESET_VAL);
            instr_p1    <= NB_INSTR'(NOP_INSTR);
            pc_plus4_p1 <= '0;
            halted      <= 1'b0;
        end else begin
            if (advance) begin
                pc_p0 <= i_pc_src ? i_pc_target : pc_plus4_p0;
            end
            // Flush outranks stall; once halted the decoder only sees bubbles.
            if (i_pipe_enabled && (i_flush || halted)) begin
                instr_p1    <= NB_INSTR'(NOP_INSTR);
                pc_plus4_p1 <= '0;
            end else if (advance) begin
                instr_p1    <= fetch_word_p0;
                pc_plus4_p1 <= pc_plus4_p0;
            end
            // A HALT on a squashed (wrong) path must not stop the machine.
            if (advance && !i_flush && fetch_is_halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Output drive from the stage registers.
    always_comb begin
        o_instruction = instr_p1;
        o_pc_plus4    = pc_plus4_p1;
        o_pc          = pc_p0;
        o_halt        = halted;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a directed table of cycles with hand-computed
// expectations, then randomized cycles checked against a rule-level model.
module tb_instruction_fetch;

    localparam int NB_PC        = 32;
    localparam int NB_INSTR     = 32;
    localparam int N_IMEM_WORDS = 1024;
    localparam int NB_IMEM_ADDR = 10;

    logic                    clk = 1'b0;
    logic                    rst, pe, st, fl, src, le;
    logic [NB_PC-1:0]        tgt;
    logic [NB_IMEM_ADDR-1:0] la;
    logic [NB_INSTR-1:0]     ld;
    logic [NB_INSTR-1:0]     o_instruction;
    logic [NB_PC-1:0]        o_pc_plus4, o_pc;
    logic                    o_halt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .NB_PC        (NB_PC),
        .NB_INSTR     (NB_INSTR),
        .N_IMEM_WORDS (N_IMEM_WORDS)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pipe_enabled (pe),
        .i_stall        (st),
        .i_flush        (fl),
        .i_pc_src       (src),
        .i_pc_target    (tgt),
        .i_load_enable  (le),
        .i_load_addr    (la),
        .i_load_data    (ld),
        .o_instruction  (o_instruction),
        .o_pc_plus4     (o_pc_plus4),
        .o_pc           (o_pc),
        .o_halt         (o_halt)
    );

    typedef struct {
        logic        rst, pe, st, fl, src;
        logic [31:0] tgt;
        logic        le;
        logic [9:0]  la;
        logic [31:0] ld;
        logic [31:0] epc, eins, ep4;
        logic        eh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic p, logic s, logic f, logic c,
                                logic [31:0] t, logic l, logic [9:0] a, logic [31:0] d,
                                logic [31:0] epc, logic [31:0] eins, logic [31:0] ep4, logic eh);
        vec_t v;
        v.rst = r; v.pe = p; v.st = s; v.fl = f; v.src = c; v.tgt = t;
        v.le = l; v.la = a; v.ld = d;
        v.epc = epc; v.eins = eins; v.ep4 = ep4; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %08h expected %08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic s, input logic f, input logic c,
                         input logic [31:0] t, input logic l, input logic [9:0] a, input logic [31:0] d);
        rst = r; pe = p; st = s; fl = f; src = c; tgt = t; le = l; la = a; ld = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: memory image and architectural registers.
    logic [31:0] mm [N_IMEM_WORDS];
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_h;

    // Apply one cycle of the fetch rules to the model using the inputs now driven.
    task automatic model_cycle();
        logic [31:0] word;
        logic        go;
        word = mm[m_pc[11:2]];
        go   = pe && !st && !m_h;
        if (rst) begin
            m_pc = 0; m_ins = 0; m_p4 = 0; m_h = 0;
        end else begin
            if (pe && (fl || m_h)) begin
                m_ins = 0; m_p4 = 0;
            end else if (go) begin
                m_ins = word; m_p4 = m_pc + 32'd4;
            end
            if (go && !fl && word == 32'hFFFF_FFFF) m_h = 1'b1;
            if (go) m_pc = src ? tgt : m_pc + 32'd4;
        end
        if (le) mm[la] = ld;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //         rst pe st fl src tgt            le  la     ld             pc             instr          pc+4         halt
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        1, 10'd0,    32'h2001_0005, 32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        1, 10'd1,    32'h2002_0007, 32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 32'h80,       1, 10'd2,    32'h2003_0009, 32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        1, 10'd3,    32'h2004_000B, 32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h4,        32'h2001_0005, 32'h4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h8,        32'h2002_0007, 32'h8, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h8,        32'h2002_0007, 32'h8, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h100,      0, 10'd0,    32'h0,         32'h8,        32'h2002_0007, 32'h8, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h8,        32'h2002_0007, 32'h8, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'hC,        32'h2003_0009, 32'hC, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,      0, 10'd0,    32'h0,         32'hC,        32'h2003_0009, 32'hC, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h40,       1, 10'd16,   32'h1234_5678, 32'h40,       32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 10'd17,   32'h0000_AAAA, 32'h44,       32'h1234_5678, 32'h44, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'hC,        1, 10'd3,    32'hFFFF_FFFF, 32'hC,        32'h0000_AAAA, 32'h48, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h20,       1, 10'd8,    32'h0000_BBBB, 32'h20,       32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 10'd2,    32'hFFFF_FFFF, 32'h24,       32'h0000_BBBB, 32'h24, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h8,        0, 10'd0,    32'h0,         32'h8,        32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'hC,        32'hFFFF_FFFF, 32'hC, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'hC,        32'h0,        32'h0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h80,       0, 10'd0,    32'h0,         32'hC,        32'h0,        32'h0,  1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 10'd1023, 32'h0000_CCCC, 32'h4,        32'h2001_0005, 32'h4, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, 10'd0,   32'h0,         32'hFFFF_FFFC, 32'h0,       32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h0,        32'h0000_CCCC, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        1, 10'd0,    32'h5555_5555, 32'h4,        32'h2001_0005, 32'h4, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0,        0, 10'd0,    32'h0,         32'h0,        32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 10'd0,    32'h0,         32'h4,        32'h5555_5555, 32'h4, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,        0, 10'd0,    32'h0,         32'h4,        32'h0,        32'h0,  0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,        0, 10'd0,    32'h0,         32'h4,        32'h0,        32'h0,  0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pe, vecs[i].st, vecs[i].fl, vecs[i].src,
                  vecs[i].tgt, vecs[i].le, vecs[i].la, vecs[i].ld);
            step();
            chk("dir_pc",    i, o_pc,          vecs[i].epc);
            chk("dir_instr", i, o_instruction, vecs[i].eins);
            chk("dir_pc4",   i, o_pc_plus4,    vecs[i].ep4);
            chk("dir_halt",  i, 32'(o_halt),   32'(vecs[i].eh));
        end

        // Fill the whole memory under reset so the model knows every word.
        m_pc = 0; m_ins = 0; m_p4 = 0; m_h = 0;
        for (int w = 0; w < N_IMEM_WORDS; w++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : $urandom();
            drive(1, $urandom_range(0, 1), 0, 0, 0, 0, 1, 10'(w), d);
            model_cycle();
            step();
        end
        chk("fill_pc",   0, o_pc,        32'h0);
        chk("fill_halt", 0, 32'(o_halt), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 90,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 15,
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 99) < 20,
                  10'($urandom_range(0, N_IMEM_WORDS - 1)),
                  ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : $urandom());
            model_cycle();
            step();
            chk("rnd_pc",    n, o_pc,          m_pc);
            chk("rnd_instr", n, o_instruction, m_ins);
            chk("rnd_pc4",   n, o_pc_plus4,    m_p4);
            chk("rnd_halt",  n, 32'(o_halt),   32'(m_h));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
